// File: rtl/marie_mem_pkg.sv
// ============================================================================
// Module : marie_mem_pkg
// Brief  : Shared types and constants for the MARIE memory responder slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package marie_mem_pkg;

    localparam int c_addr_width = 12;
    localparam int c_data_width = 16;

    // Opcodes decoded by the CPU controller from IR[15:12]
    localparam logic [3:0] c_op_load     = 4'h1;
    localparam logic [3:0] c_op_store    = 4'h2;
    localparam logic [3:0] c_op_add      = 4'h3;
    localparam logic [3:0] c_op_halt     = 4'h7;
    localparam logic [3:0] c_op_skipcond = 4'h8;
    localparam logic [3:0] c_op_jump     = 4'h9;
    localparam logic [3:0] c_op_clear    = 4'hA;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE    = 2'd0,
        REQ_READ    = 2'd1,
        REQ_WRITE   = 2'd2,
        REQ_ILLEGAL = 2'd3
    } req_kind_t;

endpackage

`default_nettype wire

// File: rtl/marie_mem_array.sv
// ============================================================================
// Module : marie_mem_array
// Brief  : DEPTH x DATA_WIDTH word storage, synchronous write, async read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module marie_mem_array
    import marie_mem_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int DEPTH      = 4096,
    parameter int IDX_W      = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/marie_mem_responder.sv
// ============================================================================
// Module : marie_mem_responder
// Brief  : cs/we/oe word memory responder with programmable read latency
//          and ready/valid handshake toward the MARIE CPU controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module marie_mem_responder
    import marie_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = c_addr_width,
    parameter int DATA_WIDTH   = c_data_width,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  err
);

    localparam int                c_idx_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                c_cnt_w    = 3;
    localparam logic [ADDR_WIDTH:0] c_depth  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_cnt_init =
        c_cnt_w'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);

    state_t                r_state;
    state_t                w_state_nxt;
    req_kind_t             w_kind;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_valid;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_pend_data;
    logic                  r_pend_oor;
    logic                  w_in_range;
    logic                  w_arr_we;
    logic [DATA_WIDTH-1:0] w_arr_rdata;
    logic [DATA_WIDTH-1:0] w_rd_value;

    assign w_in_range = ({1'b0, addr} < c_depth);

    always_comb begin
        w_kind = REQ_NONE;
        if (cs && ready) begin
            case ({we, oe})
                2'b10:   w_kind = REQ_WRITE;
                2'b01:   w_kind = REQ_READ;
                2'b11:   w_kind = REQ_ILLEGAL;
                default: w_kind = REQ_NONE;
            endcase
        end
    end

    assign w_arr_we   = (w_kind == REQ_WRITE) && w_in_range;
    // Out-of-range reads return zero regardless of what the array index aliases to
    assign w_rd_value = w_in_range ? w_arr_rdata : '0;

    marie_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (c_idx_w)
    ) u_array (
        .clk   (clk),
        .we    (w_arr_we),
        .addr  (addr[c_idx_w-1:0]),
        .wdata (wdata),
        .rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if ((w_kind == REQ_READ) && (READ_LATENCY > 1)) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == IDLE);
    end

    // Read data is captured at acceptance and parked until the latency expires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_pend_data <= '0;
            r_pend_oor  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    case (w_kind)
                        REQ_WRITE:   r_err <= !w_in_range;
                        REQ_ILLEGAL: r_err <= 1'b1;
                        REQ_READ: begin
                            if (READ_LATENCY == 1) begin
                                r_rdata <= w_rd_value;
                                r_valid <= 1'b1;
                                r_err   <= !w_in_range;
                            end else begin
                                r_cnt       <= c_cnt_init;
                                r_pend_data <= w_rd_value;
                                r_pend_oor  <= !w_in_range;
                            end
                        end
                        default: ;
                    endcase
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_rdata <= r_pend_data;
                        r_valid <= 1'b1;
                        r_err   <= r_pend_oor;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_valid;
    assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_marie_mem_responder.sv
// ============================================================================
// Module : tb_marie_mem_responder
// Brief  : Scoreboard bench over four responder configurations.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_marie_mem_responder;

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cs;
    logic        we, oe;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [3:0]  rdy, vld, er;
    logic [15:0] rd [4];

    exp_t        sb [$];
    logic [15:0] mdl [4][512];
    int          depth_of [4] = '{512, 4096, 4096, 256};
    int          valid_seen [4] = '{0, 0, 0, 0};
    int          n_vec = 0;
    int          n_err = 0;

    logic [11:0] pa [4] = '{12'h100, 12'h101, 12'h10B, 12'h10C};
    logic [15:0] pd [4] = '{16'h110C, 16'h210E, 16'h0005, 16'h0007};

    always #5 clk = ~clk;

    marie_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .DEPTH(512), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .cs(cs[0]), .we(we), .oe(oe), .addr(addr), .wdata(wdata),
        .ready(rdy[0]), .rdata(rd[0]), .rdata_valid(vld[0]), .err(er[0]));
    marie_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .DEPTH(4096), .READ_LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .cs(cs[1]), .we(we), .oe(oe), .addr(addr), .wdata(wdata),
        .ready(rdy[1]), .rdata(rd[1]), .rdata_valid(vld[1]), .err(er[1]));
    marie_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .DEPTH(4096), .READ_LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .cs(cs[2]), .we(we), .oe(oe), .addr(addr), .wdata(wdata),
        .ready(rdy[2]), .rdata(rd[2]), .rdata_valid(vld[2]), .err(er[2]));
    marie_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .DEPTH(256), .READ_LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .cs(cs[3]), .we(we), .oe(oe), .addr(addr), .wdata(wdata),
        .ready(rdy[3]), .rdata(rd[3]), .rdata_valid(vld[3]), .err(er[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (vld[k] === 1'b1) begin
                valid_seen[k]++;
                if (sb.size() == 0) begin
                    check($sformatf("unexpected_valid_%0d", k), {31'b0, vld[k]}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_id", k, e.id);
                    check($sformatf("sb_rdata_%0d", k), {16'b0, rd[k]}, {16'b0, e.data});
                    check($sformatf("sb_err_%0d", k), {31'b0, er[k]}, {31'b0, e.err});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs = '0;
        we = 1'b0;
        oe = 1'b0;
    endtask

    task automatic drive(input int k, input logic w, input logic o,
                         input logic [11:0] a, input logic [15:0] d);
        cs    = '0;
        cs[k] = 1'b1;
        we    = w;
        oe    = o;
        addr  = a;
        wdata = d;
    endtask

    // Reference behaviour of an accepted request
    task automatic model_accept(input int k);
        exp_t e;
        logic inr;
        inr = (int'(addr) < depth_of[k]);
        if (we && !oe && inr) mdl[k][addr[8:0]] = wdata;
        if (!we && oe) begin
            e.id   = k;
            e.data = inr ? mdl[k][addr[8:0]] : 16'h0000;
            e.err  = !inr;
            sb.push_back(e);
        end
    endtask

    task automatic req(input int k, input logic w, input logic o,
                       input logic [11:0] a, input logic [15:0] d);
        drive(k, w, o, a, d);
        check("ready_at_req", {31'b0, rdy[k]}, 32'd1);
        model_accept(k);
        tick();
        idle();
    endtask

    task automatic wait_valid(input int k, input int bound);
        int n;
        n = 0;
        while (vld[k] !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check("valid_timeout", {31'b0, vld[k]}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        rst   = 1'b1;
        idle();
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rst_ready", {31'b0, rdy[k]}, 32'd1);
            check("rst_rdata", {16'b0, rd[k]}, 32'd0);
            check("rst_valid", {31'b0, vld[k]}, 32'd0);
            check("rst_err",   {31'b0, er[k]},  32'd0);
        end
        rst = 1'b0;
        tick();

        // Program load, back-to-back writes
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                req(k, 1'b1, 1'b0, pa[i], pd[i]);
                check("load_err", {31'b0, er[k]}, 32'd0);
                check("load_ready", {31'b0, rdy[k]}, 32'd1);
            end
        end

        // L=1 read: valid the cycle after acceptance, single pulse
        req(0, 1'b0, 1'b1, 12'h10B, 16'h0);
        check("l1_valid", {31'b0, vld[0]}, 32'd1);
        check("l1_rdata", {16'b0, rd[0]}, 32'h0005);
        check("l1_ready", {31'b0, rdy[0]}, 32'd1);
        tick();
        check("l1_pulse", {31'b0, vld[0]}, 32'd0);
        check("l1_hold", {16'b0, rd[0]}, 32'h0005);
        req(0, 1'b0, 1'b1, 12'h100, 16'h0);
        req(0, 1'b0, 1'b1, 12'h101, 16'h0);
        tick();

        // L=3: two stall cycles then valid with ready
        req(1, 1'b0, 1'b1, 12'h10C, 16'h0);
        check("l3_stall1_ready", {31'b0, rdy[1]}, 32'd0);
        check("l3_stall1_valid", {31'b0, vld[1]}, 32'd0);
        tick();
        check("l3_stall2_ready", {31'b0, rdy[1]}, 32'd0);
        check("l3_stall2_valid", {31'b0, vld[1]}, 32'd0);
        tick();
        check("l3_valid", {31'b0, vld[1]}, 32'd1);
        check("l3_rdata", {16'b0, rd[1]}, 32'h0007);
        check("l3_ready", {31'b0, rdy[1]}, 32'd1);
        req(1, 1'b0, 1'b1, 12'h100, 16'h0);
        wait_valid(1, 5);
        tick();

        // Read-after-write
        req(0, 1'b1, 1'b0, 12'h10F, 16'hFFFF);
        req(0, 1'b0, 1'b1, 12'h10F, 16'h0);
        check("raw1_rdata", {16'b0, rd[0]}, 32'hFFFF);
        req(0, 1'b1, 1'b0, 12'h10D, 16'h0023);
        req(0, 1'b0, 1'b1, 12'h10D, 16'h0);
        check("raw2_rdata", {16'b0, rd[0]}, 32'h0023);
        tick();

        // Illegal request and out-of-range accesses
        req(0, 1'b1, 1'b0, 12'h10E, 16'h5555);
        req(0, 1'b1, 1'b1, 12'h10E, 16'h9999);
        check("ill_err", {31'b0, er[0]}, 32'd1);
        check("ill_valid", {31'b0, vld[0]}, 32'd0);
        tick();
        check("ill_err_pulse", {31'b0, er[0]}, 32'd0);
        req(0, 1'b0, 1'b1, 12'h10E, 16'h0);
        check("ill_unchanged", {16'b0, rd[0]}, 32'h5555);
        req(0, 1'b1, 1'b0, 12'h200, 16'h1234);
        check("oor_wr_err", {31'b0, er[0]}, 32'd1);
        tick();
        req(0, 1'b0, 1'b1, 12'h200, 16'h0);
        check("oor_rd_valid", {31'b0, vld[0]}, 32'd1);
        check("oor_rd_err", {31'b0, er[0]}, 32'd1);
        check("oor_rd_rdata", {16'b0, rd[0]}, 32'h0000);
        tick();

        // L=4: abandon an outstanding read with reset
        req(2, 1'b0, 1'b1, 12'h10B, 16'h0);
        wait_valid(2, 6);
        tick();
        drive(2, 1'b0, 1'b1, 12'h101, 16'h0);
        check("l4_ready_pre", {31'b0, rdy[2]}, 32'd1);
        tick();
        idle();
        tick();
        vcount = valid_seen[2];
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {31'b0, rdy[2]}, 32'd1);
        check("mid_rst_rdata", {16'b0, rd[2]}, 32'h0000);
        check("mid_rst_valid", {31'b0, vld[2]}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("abandoned_no_valid", valid_seen[2] - vcount, 32'd0);
        req(2, 1'b0, 1'b1, 12'h101, 16'h0);
        wait_valid(2, 8);
        check("post_rst_rdata", {16'b0, rd[2]}, 32'h210E);
        tick();

        // L=2, DEPTH=256: stall compliance and boundary addresses
        req(3, 1'b1, 1'b0, 12'h020, 16'h0042);
        req(3, 1'b1, 1'b0, 12'h021, 16'h0011);
        req(3, 1'b0, 1'b1, 12'h020, 16'h0);
        drive(3, 1'b1, 1'b0, 12'h021, 16'h0077);
        check("stall_ready", {31'b0, rdy[3]}, 32'd0);
        tick();
        idle();
        req(3, 1'b0, 1'b1, 12'h021, 16'h0);
        drive(3, 1'b1, 1'b0, 12'h020, 16'h0099);
        check("hold_ready0", {31'b0, rdy[3]}, 32'd0);
        tick();
        check("hold_ready1", {31'b0, rdy[3]}, 32'd1);
        model_accept(3);
        tick();
        idle();
        req(3, 1'b0, 1'b1, 12'h020, 16'h0);
        wait_valid(3, 4);
        check("held_wr_rdata", {16'b0, rd[3]}, 32'h0099);
        tick();
        req(3, 1'b1, 1'b0, 12'h0FF, 16'h0EEE);
        check("top_wr_err", {31'b0, er[3]}, 32'd0);
        req(3, 1'b0, 1'b1, 12'h0FF, 16'h0);
        wait_valid(3, 4);
        tick();
        req(3, 1'b0, 1'b1, 12'h100, 16'h0);
        wait_valid(3, 4);
        check("depth_rd_err", {31'b0, er[3]}, 32'd1);

        repeat (3) tick();
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
